// File: rtl/s2p.sv
// Serial-to-parallel receiver: assembles W-bit words from a vld-qualified bit
// stream into a holding register, flagging frame breaks and overruns.
module s2p #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         data,
  input  logic         vld,
  input  logic         rd,
  input  logic         clr,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         busy,
  output logic         err,
  output logic         ovf
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [W-1:0]     sr_r, sr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [W-1:0]     dout_r, dout_s;
  logic             full_r, full_s;
  logic             busy_r, busy_s;
  logic             err_r, err_s;
  logic             ovf_r, ovf_s;
  logic [W-1:0]     shifted_s;
  logic             done_s;
  logic             brk_s;
  logic             drop_s;

  // Next-state, datapath and flag update logic.
  always_comb begin
    state_s   = state_r;
    sr_s      = sr_r;
    cnt_s     = cnt_r;
    dout_s    = dout_r;
    full_s    = full_r;
    done_s    = 1'b0;
    brk_s     = 1'b0;
    drop_s    = 1'b0;
    if (MSB_FIRST) begin
      shifted_s = {sr_r[W-2:0], data};
    end else begin
      shifted_s = {data, sr_r[W-1:1]};
    end

    case (state_r)
      IDLE: begin
        if (vld) begin
          sr_s    = shifted_s;
          cnt_s   = CNT_W'(1);
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (vld) begin
          sr_s = shifted_s;
          if (cnt_r == LAST_CNT) begin
            done_s  = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          // Frame break: the partial word is thrown away.
          brk_s   = 1'b1;
          sr_s    = {W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        sr_s    = {W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase

    // A read in the completion cycle frees the slot for the new word.
    if (done_s) begin
      if (!full_r || rd) begin
        dout_s = shifted_s;
        full_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else if (rd) begin
      full_s = 1'b0;
    end else begin
      full_s = full_r;
    end

    err_s  = brk_s  | (err_r & ~clr);
    ovf_s  = drop_s | (ovf_r & ~clr);
    busy_s = (state_s == SHIFT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r <= IDLE;
      sr_r    <= {W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      dout_r  <= {W{1'b0}};
      full_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      cnt_r   <= cnt_s;
      dout_r  <= dout_s;
      full_r  <= full_s;
      busy_r  <= busy_s;
      err_r   <= err_s;
      ovf_r   <= ovf_s;
    end
  end

  assign dout = dout_r;
  assign full = full_r;
  assign busy = busy_r;
  assign err  = err_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_s2p.sv
// Bench for s2p: directed vector table, a bit-order sequence, and random
// traffic checked against a queue-based receiver model for both bit orders.
module tb_s2p;
  localparam int W = 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0, data = 1'b0, vld = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [W-1:0] dout_m, dout_l;
  logic full_m, busy_m, err_m, ovf_m;
  logic full_l, busy_l, err_l, ovf_l;

  s2p #(.W(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .n_rst(n_rst), .data(data), .vld(vld), .rd(rd), .clr(clr),
    .dout(dout_m), .full(full_m), .busy(busy_m), .err(err_m), .ovf(ovf_m)
  );

  s2p #(.W(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .n_rst(n_rst), .data(data), .vld(vld), .rd(rd), .clr(clr),
    .dout(dout_l), .full(full_l), .busy(busy_l), .err(err_l), .ovf(ovf_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic n, v, d, r, c;
    logic [3:0] dout;
    logic full, busy, err, ovf;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference receiver: bits collected in a queue, word built arithmetically.
  bit q[$];
  logic [W-1:0] md_m = '0, md_l = '0;
  logic mf = 1'b0, me = 1'b0, mo = 1'b0;

  task automatic model(input logic n, input logic v, input logic d,
                       input logic r, input logic c);
    bit done = 1'b0, brk = 1'b0, drop = 1'b0;
    int wm = 0, wl = 0;
    if (!n) begin
      q.delete();
      md_m = '0; md_l = '0; mf = 1'b0; me = 1'b0; mo = 1'b0;
    end else begin
      if (v) begin
        q.push_back(d);
        if (q.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wm += int'(q[i]) * (1 << (W - 1 - i));
            wl += int'(q[i]) * (1 << i);
          end
          q.delete();
        end
      end else if (q.size() != 0) begin
        brk = 1'b1;
        q.delete();
      end
      if (done) begin
        if (!mf || r) begin
          md_m = W'(wm); md_l = W'(wl); mf = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (r) begin
        mf = 1'b0;
      end
      me = brk | (me & ~c);
      mo = drop | (mo & ~c);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic n, input logic v, input logic d,
                      input logic r, input logic c);
    logic mb;
    n_rst = n; vld = v; data = d; rd = r; clr = c;
    @(posedge clk);
    model(n, v, d, r, c);
    #1;
    mb = (q.size() != 0);
    check("model_msb", {dout_m, full_m, busy_m, err_m, ovf_m}, {md_m, mf, mb, me, mo});
    check("model_lsb", {dout_l, full_l, busy_l, err_l, ovf_l}, {md_l, mf, mb, me, mo});
  endtask

  task automatic add(input logic n, input logic v, input logic d, input logic r,
                     input logic c, input logic [3:0] dv, input logic f,
                     input logic b, input logic e, input logic o);
    vec_t x;
    x.n = n; x.v = v; x.d = d; x.r = r; x.c = c;
    x.dout = dv; x.full = f; x.busy = b; x.err = e; x.ovf = o;
    tbl.push_back(x);
  endtask

  initial begin
    // n v d r c | dout full busy err ovf  (expected after the edge, MSB-first)
    add(1'b0,1'b1,1'b1,1'b0,1'b0, 4'h0,1'b0,1'b0,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b0,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b0,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h9,1'b1,1'b0,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,1'b1,1'b0, 4'h9,1'b0,1'b0,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h9,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h9,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,1'b0,1'b0, 4'h9,1'b0,1'b0,1'b1,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h9,1'b0,1'b1,1'b1,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h9,1'b0,1'b1,1'b1,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h9,1'b0,1'b1,1'b1,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h6,1'b1,1'b0,1'b1,1'b0);
    add(1'b1,1'b0,1'b0,1'b0,1'b1, 4'h6,1'b1,1'b0,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,1'b1,1'b0, 4'h6,1'b0,1'b0,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h6,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h6,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h6,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'hA,1'b1,1'b0,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'hA,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'hA,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'hA,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'hA,1'b1,1'b0,1'b0,1'b1);
    add(1'b1,1'b0,1'b0,1'b0,1'b1, 4'hA,1'b1,1'b0,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'hA,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'hA,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'hA,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b1,1'b0, 4'hC,1'b1,1'b0,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'hC,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'hC,1'b1,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'hC,1'b1,1'b1,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b0,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,1'b1,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b0,1'b0, 4'h9,1'b1,1'b0,1'b0,1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].n, tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      check($sformatf("vec%0d", i), {dout_m, full_m, busy_m, err_m, ovf_m},
            {tbl[i].dout, tbl[i].full, tbl[i].busy, tbl[i].err, tbl[i].ovf});
    end

    // Bit order: 1001 is symmetric, 1100 is not.
    check("lsb_1001", {4'h0, dout_l}, 8'h09);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("msb_1100", {4'h0, dout_m}, 8'h0C);
    check("lsb_1100", {4'h0, dout_l}, 8'h03);
    check("lsb_full", {7'h00, full_l}, 8'h01);

    // Random traffic: mostly valid bits, occasional breaks, reads, clears, resets.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/s2p.md
# s2p

Serial-to-parallel receiver. It is the receive end of the serial link driven by `p2s`: it samples the `data`/`vld` pair one bit per clock, assembles `W`-bit words and presents each completed word in a holding register until a consumer reads it. Partial words are flagged as frame errors. Words that arrive while the holding register is still occupied are flagged as overruns.

## Interface
- `W`, default 4: word width in bits; legal range is W ≥ 2.
- `MSB_FIRST`, default 1: when 1, the first received bit lands in `dout[W-1]`; when 0, it lands in `dout[0]`.

- `clk`, input, 1: system clock; all logic uses the rising edge.
- `n_rst`, input, 1: reset, synchronous and active-low. It is sampled on the rising edge of `clk` and has priority over every other input.
- `data`, input, 1: serial bit; valid only when `vld`=1.
- `vld`, input, 1: qualifies `data`; must stay high for W consecutive cycles per word.
- `rd`, input, 1: consumer read strobe; pops the holding register.
- `clr`, input, 1: synchronous clear of the sticky `err` and `ovf` flags.
- `dout`, output, W: holding register, containing the last completed word.
- `full`, output, 1: `dout` holds an unread word.
- `busy`, output, 1: a word is partially received (FSM in SHIFT).
- `err`, output, 1: sticky frame error.
- `ovf`, output, 1: sticky overrun.

## Operation
- Registers: state (IDLE/SHIFT), shift register `sr[W-1:0]`, bit counter `cnt` of width clog2(W+1), `dout`, `full`, `err`, `ovf`.
- Reset values (`n_rst`=0 at an edge):
  - state = IDLE, `sr`=0, `cnt`=0.
  - `dout`=0, `full`=0, `busy`=0, `err`=0, `ovf`=0.
  - A word in progress is discarded silently; `err` is not set.
- Shift direction:
  - MSB_FIRST=1: `sr <= {sr[W-2:0], data}`.
  - MSB_FIRST=0: `sr <= {data, sr[W-1:1]}`.
- IDLE:
  - `vld`=1: shift in `data`, set `cnt`=1, go to SHIFT.
  - `vld`=0: hold.
- SHIFT with `vld`=1: shift in `data` and increment `cnt`.
  - If `cnt` was W-1, this is the final bit, called the completion event. The assembled word is the shifted `sr` value including the current bit. Set `cnt` to 0 and go to IDLE.
- SHIFT with `vld`=0 (frame break):
  - Set `err`=1, discard `sr`, set `cnt` to 0, go to IDLE.
  - `dout` and `full` are unchanged.
- Completion event:
  - If `full`=0, or `full`=1 with `rd`=1 in the same cycle: load `dout` with the word and set `full`=1.
  - If `full`=1 and `rd`=0: set `ovf`=1, drop the new word, keep `dout`.
- `rd`=1 with `full`=1 and no completion event: `full` goes to 0 next cycle; `dout` keeps its value.
- `rd`=1 with `full`=0: ignored.
- `clr`=1: `err` and `ovf` go to 0 next cycle.
  - If a set condition for a flag occurs in the same cycle as `clr`, the set wins.
  - `clr` never affects `dout`, `full` or the FSM.
- `busy` = (state == SHIFT), driven from a register.
- Back-to-back streaming: `vld` held high for k·W cycles produces k completion events with no gap cycles. The cycle after a completion starts in IDLE and accepts a bit immediately.

## Timing
- Bit i (i = 0..W-1) is sampled at the i-th rising edge where `vld`=1 within the word.
- `full` and the new `dout` are visible in the cycle after the edge that samples bit W-1, i.e. one cycle of latency from the last bit.
- `err` is visible in the cycle after the first edge in SHIFT that sees `vld`=0.
- `ovf` is visible in the cycle after the dropped completion.
- `busy` rises in the cycle after the first bit is sampled. It falls in the cycle after the completion event or the frame break.
- `rd` takes effect at the edge where it is sampled high; it is a level-sampled strobe, and the consumer holds it for one cycle per word.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `n_rst`=0 for 2 cycles with `vld` toggling. All outputs read 0 and nothing is captured.
- Basic word: W=4, MSB_FIRST=1, drive bits 1,0,0,1 with `vld`=1 for 4 cycles.
  - Next cycle: `dout`=4'b1001, `full`=1, `busy`=0.
  - Pulse `rd`: `full`=0 next cycle, `dout` still 4'b1001.
- LSB order: same bit stream with MSB_FIRST=0 gives `dout`=4'b1001 (symmetric pattern). Bits 1,1,0,0 give `dout`=4'b0011.
- Frame error: `vld`=1 for 2 bits, then 0.
  - Next cycle: `err`=1, `busy`=0, `full` and `dout` unchanged.
  - A following full 4-bit word 0110 is received correctly.
  - `clr` then drops `err` to 0.
- Overrun and simultaneous read:
  - Stream 1010 then 0101 back-to-back with no `rd`: `dout`=4'b1010, `ovf`=1.
  - Then clear with `clr`. Stream 1100, and pulse `rd` in that word's final-bit cycle: `dout`=4'b1100, `full` stays 1, `ovf`=0.
- Reset mid-word: after 3 bits of a word, assert `n_rst`=0 for one cycle.
  - All outputs return to 0 and `err` stays 0.
  - A subsequent 4-bit word 1001 yields `dout`=4'b1001.
